// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift step per clock.
// Latency WIDTH+1 cycles from start to valid; start ignored (not queued) while busy.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = DIGITS * 4;

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    work;
  logic             acc;
  logic [CW-1:0]    cnt;

  logic             load, step, last;
  logic [BW-1:0]    corr, shifted;
  logic             out_bit;
  logic [DIGITS-1:0] blank_next;
  logic             zero_above;

  // Add-3 correction, then shift; the top bit falling out feeds the overflow flag.
  always_comb begin
    corr = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5)
        corr[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
    shifted = {corr[BW-2:0], sreg[WIDTH-1]};
    out_bit = corr[BW-1];
  end

  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (shifted[4*k +: 4] == 4'd0);
      blank_next[k] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == '0) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      work     <= '0;
      acc      <= 1'b0;
      cnt      <= '0;
      valid    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      blank    <= ~DIGITS'(1);
    end else begin
      valid <= 1'b0;
      if (load) begin
        sreg <= bin;
        work <= '0;
        acc  <= 1'b0;
        cnt  <= CW'(WIDTH - 1);
      end else if (step) begin
        sreg <= sreg << 1;
        work <= shifted;
        acc  <= acc | out_bit;
        cnt  <= cnt - CW'(1);
        if (last) begin
          bcd      <= shifted;
          overflow <= acc | out_bit;
          blank    <= blank_next;
          valid    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq across three parameter sets.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [15:0] bin0 = '0, bin1 = '0;
  logic [5:0]  bin2 = '0;
  logic rdy0, rdy1, rdy2, v0, v1, v2, ov0, ov1, ov2;
  logic [19:0] bcd0;
  logic [15:0] bcd1;
  logic [7:0]  bcd2;
  logic [4:0]  bl0;
  logic [3:0]  bl1;
  logic [1:0]  bl2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u_d5 (
    .clk(clk), .rst(rst), .start(st0), .bin(bin0), .ready(rdy0), .valid(v0),
    .bcd(bcd0), .blank(bl0), .overflow(ov0));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st1), .bin(bin1), .ready(rdy1), .valid(v1),
    .bcd(bcd1), .blank(bl1), .overflow(ov1));
  bin2bcd_seq #(.WIDTH(6), .DIGITS(2)) u_d2 (
    .clk(clk), .rst(rst), .start(st2), .bin(bin2), .ready(rdy2), .valid(v2),
    .bcd(bcd2), .blank(bl2), .overflow(ov2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic [15:0] b);
    case (sel)
      0:       begin st0 = s; bin0 = b; end
      1:       begin st1 = s; bin1 = b; end
      default: begin st2 = s; bin2 = b[5:0]; end
    endcase
  endtask

  function automatic logic vld(input int sel);
    case (sel)
      0:       return v0;
      1:       return v1;
      default: return v2;
    endcase
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic ovf(input int sel);
    case (sel)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [31:0] rbcd(input int sel);
    case (sel)
      0:       return {12'd0, bcd0};
      1:       return {16'd0, bcd1};
      default: return {24'd0, bcd2};
    endcase
  endfunction

  function automatic logic [31:0] rblank(input int sel);
    case (sel)
      0:       return {27'd0, bl0};
      1:       return {28'd0, bl1};
      default: return {30'd0, bl2};
    endcase
  endfunction

  // One accepted conversion; with noise, start/bin toggle randomly while busy.
  task automatic run(input int sel, input logic [15:0] b, input logic [31:0] eb,
                     input logic [31:0] ebl, input logic eo, input bit noise,
                     input int elat, input string tag);
    int n;
    int nv;
    @(negedge clk);
    check({tag, ":ready"}, {31'd0, rdy(sel)}, 32'd1);
    drive(sel, 1'b1, b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (noise) drive(sel, 1'($urandom_range(0, 1)), 16'($urandom));
      else       drive(sel, 1'b0, 16'($urandom));
    end while (!vld(sel) && n < 60);
    drive(sel, 1'b0, 16'd0);
    check({tag, ":valid"}, {31'd0, vld(sel)}, 32'd1);
    check({tag, ":latency"}, n, elat);
    check({tag, ":bcd"}, rbcd(sel), eb);
    check({tag, ":blank"}, rblank(sel), ebl);
    check({tag, ":overflow"}, {31'd0, ovf(sel)}, {31'd0, eo});
    nv = 0;
    repeat (25) begin
      @(negedge clk);
      if (vld(sel)) nv++;
    end
    check({tag, ":extra_valid"}, nv, 0);
    check({tag, ":hold_bcd"}, rbcd(sel), eb);
  endtask

  initial begin
    int n;
    int nv;
    logic [7:0] eb2;
    rst = 1'b0;
    #1 rst = 1'b1;
    #10;
    check("rst:ready", {31'd0, rdy0}, 32'd1);
    check("rst:valid", {31'd0, v0}, 32'd0);
    check("rst:bcd", {12'd0, bcd0}, 32'd0);
    check("rst:blank5", {27'd0, bl0}, 32'b11110);
    check("rst:blank4", {28'd0, bl1}, 32'b1110);
    check("rst:blank2", {30'd0, bl2}, 32'b10);
    check("rst:overflow", {31'd0, ov0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 16'd65535, 32'h65535, 32'b00000, 1'b0, 1'b0, 17, "d5_65535");
    run(0, 16'd0,     32'h00000, 32'b11110, 1'b0, 1'b0, 17, "d5_zero");
    run(0, 16'd907,   32'h00907, 32'b11000, 1'b0, 1'b0, 17, "d5_907");
    run(1, 16'd12345, 32'h2345,  32'b0000,  1'b1, 1'b0, 17, "d4_12345");
    run(1, 16'd9999,  32'h9999,  32'b0000,  1'b0, 1'b0, 17, "d4_9999");
    run(1, 16'd42,    32'h0042,  32'b1100,  1'b0, 1'b0, 17, "d4_42");
    run(0, 16'd31416, 32'h31416, 32'b00000, 1'b0, 1'b1, 17, "d5_noise");

    // Asynchronous reset in the middle of a conversion, between clock edges.
    @(negedge clk);
    drive(0, 1'b1, 16'd4321);
    @(negedge clk);
    drive(0, 1'b0, 16'd0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst:ready", {31'd0, rdy0}, 32'd1);
    check("midrst:valid", {31'd0, v0}, 32'd0);
    check("midrst:bcd", {12'd0, bcd0}, 32'd0);
    check("midrst:blank", {27'd0, bl0}, 32'b11110);
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (v0) nv++;
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (v0) nv++;
    end
    check("midrst:no_valid", nv, 0);
    run(0, 16'd4321, 32'h04321, 32'b10000, 1'b0, 1'b0, 17, "d5_after_rst");

    // Exhaustive 6-bit sweep with start held high: back-to-back conversions.
    @(negedge clk);
    drive(2, 1'b1, 16'd0);
    for (int i = 0; i < 64; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!v2 && n < 20);
      if (i < 63) drive(2, 1'b1, 16'(i + 1));
      else        drive(2, 1'b0, 16'd0);
      eb2 = 8'(((i / 10) * 16) + (i % 10));
      check("sweep:valid", {31'd0, v2}, 32'd1);
      check("sweep:latency", n, 7);
      check("sweep:bcd", {24'd0, bcd2}, {24'd0, eb2});
      check("sweep:blank", {30'd0, bl2}, (i < 10) ? 32'b10 : 32'b00);
      check("sweep:overflow", {31'd0, ov2}, 32'd0);
    end
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
